// File: rtl/scoreboard_multi_pkg.sv
// Shared types and helpers for the N-player scoreboard: game state encoding,
// player-index width and the binary-to-BCD converter used by the display path.
package scoreboard_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2
  } game_state_e;

  // Player index width; a single bit is kept even for two players.
  function automatic int player_width(input int n_players);
    return (n_players > 2) ? $clog2(n_players) : 1;
  endfunction

  // Scores never exceed 99, so nine conditional subtractions of ten always
  // leave the ones digit in the remainder.
  function automatic logic [7:0] bin_to_bcd(input logic [7:0] bin);
    logic [7:0] rem;
    logic [3:0] tens;
    rem  = bin;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      tens = (rem >= 8'd10) ? tens + 4'd1 : tens;
      rem  = (rem >= 8'd10) ? rem - 8'd10 : rem;
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/scoreboard_multi_if.sv
// Control and display bundle of the scoreboard core; the master side drives
// game control and button pulses, the slave side is the scoreboard itself.
interface scoreboard_multi_if #(
  parameter int N_PLAYERS = 2,
  parameter int SBW       = 7,
  parameter int PBW       = 1
);
  logic                       new_game_i;
  logic [N_PLAYERS-1:0]       up_i;
  logic [N_PLAYERS-1:0]       down_i;
  logic [N_PLAYERS*SBW-1:0]   score_o;
  logic [1:0]                 state_o;
  logic                       won_o;
  logic [PBW-1:0]             winner_o;
  logic [PBW-1:0]             disp_player_o;
  logic [3:0]                 disp_tens_o;
  logic [3:0]                 disp_ones_o;
  logic                       disp_blank_o;

  modport master (
    output new_game_i, up_i, down_i,
    input  score_o, state_o, won_o, winner_o,
    input  disp_player_o, disp_tens_o, disp_ones_o, disp_blank_o
  );

  modport slave (
    input  new_game_i, up_i, down_i,
    output score_o, state_o, won_o, winner_o,
    output disp_player_o, disp_tens_o, disp_ones_o, disp_blank_o
  );
endinterface

// File: rtl/scoreboard_multi_score_channel.sv
// One player's score: saturating up/down counter with enable and a
// synchronous clear that takes priority over counting.
module scoreboard_multi_score_channel #(
  parameter int MAX_SCORE = 99,
  parameter int SBW       = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           srst,
  input  logic           en,
  input  logic           up,
  input  logic           down,
  output logic [SBW-1:0] score
);

  localparam logic [SBW-1:0] SCORE_MAX = SBW'(MAX_SCORE);
  localparam logic [SBW-1:0] SCORE_ONE = SBW'(1);

  logic [SBW-1:0] score_r;
  logic           inc_s;
  logic           dec_s;

  // Opposing pulses cancel; both ends of the range hold.
  always_comb begin
    inc_s = 1'b0;
    dec_s = 1'b0;
    if (en) begin
      inc_s = up && !down && (score_r != SCORE_MAX);
      dec_s = down && !up && (score_r != '0);
    end else begin
      inc_s = 1'b0;
      dec_s = 1'b0;
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_r <= '0;
    end else if (srst) begin
      score_r <= '0;
    end else if (inc_s) begin
      score_r <= score_r + SCORE_ONE;
    end else if (dec_s) begin
      score_r <= score_r - SCORE_ONE;
    end else begin
      score_r <= score_r;
    end
  end

  assign score = score_r;

endmodule

// File: rtl/scoreboard_multi.sv
// N-player scoreboard core: per-player score channels, game FSM with win
// detection, rotating display slot with winner blink, and BCD digit registers.
module scoreboard_multi
  import scoreboard_multi_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int MAX_SCORE  = 99,
  parameter int WIN_SCORE  = 21,
  parameter int WIN_BY_TWO = 1,
  parameter int DISP_TICKS = 1000
) (
  input  logic               clk_1khz_i,
  input  logic               rst_ni,
  scoreboard_multi_if.slave  bus
);

  localparam int SBW = $clog2(MAX_SCORE + 1);
  localparam int PBW = player_width(N_PLAYERS);
  localparam int CW  = $clog2(DISP_TICKS);

  localparam logic [CW-1:0]  SLOT_LAST   = CW'(DISP_TICKS - 1);
  localparam logic [CW-1:0]  SLOT_ONE    = CW'(1);
  localparam logic [PBW-1:0] PLAYER_LAST = PBW'(N_PLAYERS - 1);
  localparam logic [PBW-1:0] PLAYER_ONE  = PBW'(1);
  localparam logic [SBW:0]   WIN_EXT     = (SBW + 1)'(WIN_SCORE);
  localparam logic [SBW:0]   LEAD_MIN    = (SBW + 1)'(2);

  game_state_e          state_r;
  game_state_e          state_next_s;
  logic                 srst_s;
  logic                 chan_en_s;
  logic [N_PLAYERS-1:0] up_mask_s;
  logic [N_PLAYERS-1:0] down_mask_s;
  logic [SBW-1:0]       score_s [N_PLAYERS];
  logic [N_PLAYERS-1:0] win_vec_s;
  logic                 win_any_s;
  logic [PBW-1:0]       win_idx_s;
  logic                 won_entry_s;
  logic                 won_r;
  logic [PBW-1:0]       winner_r;
  logic [CW-1:0]        slot_cnt_r;
  logic [PBW-1:0]       disp_player_r;
  logic                 disp_blank_r;
  logic [SBW-1:0]       shown_score_s;
  logic [3:0]           disp_tens_r;
  logic [3:0]           disp_ones_r;

  assign srst_s    = bus.new_game_i;
  assign chan_en_s = (state_r != ST_WON);

  // Per-state button gating: IDLE only accepts clean up pulses, WON accepts nothing.
  always_comb begin
    up_mask_s   = '0;
    down_mask_s = '0;
    case (state_r)
      ST_IDLE: begin
        up_mask_s   = bus.up_i & ~bus.down_i;
        down_mask_s = '0;
      end
      ST_PLAY: begin
        up_mask_s   = bus.up_i;
        down_mask_s = bus.down_i;
      end
      ST_WON: begin
        up_mask_s   = '0;
        down_mask_s = '0;
      end
      default: begin
        up_mask_s   = '0;
        down_mask_s = '0;
      end
    endcase
  end

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_chan
    scoreboard_multi_score_channel #(
      .MAX_SCORE (MAX_SCORE),
      .SBW       (SBW)
    ) u_chan (
      .clk   (clk_1khz_i),
      .rst_n (rst_ni),
      .srst  (srst_s),
      .en    (chan_en_s),
      .up    (up_mask_s[g]),
      .down  (down_mask_s[g]),
      .score (score_s[g])
    );
    assign bus.score_o[g*SBW +: SBW] = score_s[g];
  end

  // Win comparator array on registered scores, one extra bit so +2 cannot wrap.
  always_comb begin
    win_vec_s = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      win_vec_s[p] = ({1'b0, score_s[p]} >= WIN_EXT);
      for (int q = 0; q < N_PLAYERS; q++) begin
        if ((q != p) && (WIN_BY_TWO != 0) &&
            ({1'b0, score_s[p]} < ({1'b0, score_s[q]} + LEAD_MIN))) begin
          win_vec_s[p] = 1'b0;
        end else begin
          win_vec_s[p] = win_vec_s[p];
        end
      end
    end
  end

  // Lowest-index winner: scan downward so the smallest index is written last.
  always_comb begin
    win_idx_s = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (win_vec_s[p]) begin
        win_idx_s = PBW'(p);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  assign win_any_s = |win_vec_s;

  // Game FSM next state; a new game request overrides everything else.
  always_comb begin
    state_next_s = state_r;
    if (srst_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = (|(bus.up_i & ~bus.down_i)) ? ST_PLAY : ST_IDLE;
        ST_PLAY: state_next_s = win_any_s ? ST_WON : ST_PLAY;
        ST_WON:  state_next_s = ST_WON;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  assign won_entry_s = (state_r == ST_PLAY) && (state_next_s == ST_WON);

  // Game state, won flag and latched winner.
  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      won_r    <= 1'b0;
      winner_r <= '0;
    end else begin
      state_r <= state_next_s;
      won_r   <= (state_next_s == ST_WON);
      if (won_entry_s) begin
        winner_r <= win_idx_s;
      end else if (srst_s) begin
        winner_r <= '0;
      end else begin
        winner_r <= winner_r;
      end
    end
  end

  // Display slot counter: rotates players in IDLE/PLAY, blinks the winner in WON.
  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_cnt_r    <= '0;
      disp_player_r <= '0;
      disp_blank_r  <= 1'b0;
    end else if (srst_s) begin
      slot_cnt_r    <= '0;
      disp_player_r <= '0;
      disp_blank_r  <= 1'b0;
    end else if (won_entry_s) begin
      slot_cnt_r    <= '0;
      disp_player_r <= win_idx_s;
      disp_blank_r  <= 1'b0;
    end else if (state_r == ST_WON) begin
      slot_cnt_r    <= (slot_cnt_r == SLOT_LAST) ? '0 : slot_cnt_r + SLOT_ONE;
      disp_player_r <= disp_player_r;
      disp_blank_r  <= (slot_cnt_r == SLOT_LAST) ? ~disp_blank_r : disp_blank_r;
    end else if (slot_cnt_r == SLOT_LAST) begin
      slot_cnt_r    <= '0;
      disp_player_r <= (disp_player_r == PLAYER_LAST) ? '0 : disp_player_r + PLAYER_ONE;
      disp_blank_r  <= 1'b0;
    end else begin
      slot_cnt_r    <= slot_cnt_r + SLOT_ONE;
      disp_player_r <= disp_player_r;
      disp_blank_r  <= 1'b0;
    end
  end

  // Select the shown player's score without indexing past N_PLAYERS.
  always_comb begin
    shown_score_s = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (disp_player_r == PBW'(p)) begin
        shown_score_s = score_s[p];
      end else begin
        shown_score_s = shown_score_s;
      end
    end
  end

  // BCD digit registers.
  always_ff @(posedge clk_1khz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_tens_r <= 4'd0;
      disp_ones_r <= 4'd0;
    end else begin
      {disp_tens_r, disp_ones_r} <= bin_to_bcd(8'(shown_score_s));
    end
  end

  assign bus.state_o       = state_r;
  assign bus.won_o         = won_r;
  assign bus.winner_o      = winner_r;
  assign bus.disp_player_o = disp_player_r;
  assign bus.disp_tens_o   = disp_tens_r;
  assign bus.disp_ones_o   = disp_ones_r;
  assign bus.disp_blank_o  = disp_blank_r;

endmodule

// File: tb/tb_scoreboard_multi.sv
// Bench for scoreboard_multi (3 players, 4-tick display slots): directed game
// scenarios followed by random button traffic, all checked against a score model.
module tb_scoreboard_multi;

  localparam int N    = 3;
  localparam int MAXS = 99;
  localparam int WINS = 21;
  localparam int WB2  = 1;
  localparam int DT   = 4;
  localparam int SBW  = 7;
  localparam int PBW  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scoreboard_multi_if #(.N_PLAYERS(N), .SBW(SBW), .PBW(PBW)) sb_if ();

  scoreboard_multi #(
    .N_PLAYERS  (N),
    .MAX_SCORE  (MAXS),
    .WIN_SCORE  (WINS),
    .WIN_BY_TWO (WB2),
    .DISP_TICKS (DT)
  ) dut (
    .clk_1khz_i (clk),
    .rst_ni     (rst_n),
    .bus        (sb_if)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: game state 0=IDLE 1=PLAY 2=WON.
  int m_score [N];
  int m_state, m_won, m_winner, m_disp, m_slot, m_blank, m_tens, m_ones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < N; p++)
      check($sformatf("score%0d", p), 32'(sb_if.score_o[p*SBW +: SBW]), m_score[p]);
    check("state", 32'(sb_if.state_o), m_state);
    check("won", 32'(sb_if.won_o), m_won);
    check("winner", 32'(sb_if.winner_o), m_winner);
    check("disp_player", 32'(sb_if.disp_player_o), m_disp);
    check("disp_tens", 32'(sb_if.disp_tens_o), m_tens);
    check("disp_ones", 32'(sb_if.disp_ones_o), m_ones);
    check("disp_blank", 32'(sb_if.disp_blank_o), m_blank);
  endtask

  function automatic void model_reset();
    for (int p = 0; p < N; p++) m_score[p] = 0;
    m_state = 0; m_won = 0; m_winner = 0;
    m_disp = 0; m_slot = 0; m_blank = 0; m_tens = 0; m_ones = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] up, input logic [N-1:0] dn, input logic ng);
    int  old [N];
    int  w;
    bit  any, ok;
    old = m_score;
    m_tens = old[m_disp] / 10;
    m_ones = old[m_disp] % 10;
    if (ng) begin
      for (int p = 0; p < N; p++) m_score[p] = 0;
      m_state = 0; m_won = 0; m_winner = 0; m_disp = 0; m_slot = 0; m_blank = 0;
      return;
    end
    w = -1;
    if (m_state == 0) begin
      any = 1'b0;
      for (int p = 0; p < N; p++)
        if (up[p] && !dn[p]) begin
          any = 1'b1;
          if (m_score[p] < MAXS) m_score[p]++;
        end
      if (any) m_state = 1;
    end else if (m_state == 1) begin
      for (int p = 0; p < N; p++) begin
        if (w < 0 && old[p] >= WINS) begin
          ok = 1'b1;
          if (WB2 != 0)
            for (int q = 0; q < N; q++)
              if (q != p && old[p] < old[q] + 2) ok = 1'b0;
          if (ok) w = p;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (up[p] && !dn[p] && m_score[p] < MAXS) m_score[p]++;
        if (dn[p] && !up[p] && m_score[p] > 0) m_score[p]--;
      end
    end
    if (w >= 0) begin
      m_state = 2; m_won = 1; m_winner = w;
      m_disp = w; m_slot = 0; m_blank = 0;
    end else if (m_state == 2) begin
      m_slot++;
      if (m_slot == DT) begin m_slot = 0; m_blank = 1 - m_blank; end
    end else begin
      m_slot++;
      if (m_slot == DT) begin m_slot = 0; m_disp = (m_disp + 1) % N; end
    end
  endfunction

  task automatic cycle(input logic [N-1:0] up, input logic [N-1:0] dn, input logic ng);
    sb_if.up_i = up;
    sb_if.down_i = dn;
    sb_if.new_game_i = ng;
    @(posedge clk);
    model_step(up, dn, ng);
    @(negedge clk);
    sb_if.up_i = '0;
    sb_if.down_i = '0;
    sb_if.new_game_i = 1'b0;
    check_all();
  endtask

  initial begin
    logic [N-1:0] ru, rd;
    rst_n = 1'b0;
    sb_if.up_i = '0;
    sb_if.down_i = '0;
    sb_if.new_game_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (3) cycle(3'b000, 3'b000, 1'b0);

    // Start, cancelling pulses, both-up, down at zero.
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b001, 3'b001, 1'b0);
    cycle(3'b011, 3'b000, 1'b0);
    cycle(3'b000, 3'b100, 1'b0);

    // Equal climb to saturation (lead never reaches two), then up at ceiling.
    repeat (110) cycle(3'b111, 3'b000, 1'b0);
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b0);

    // New game overrides a concurrent up pulse.
    cycle(3'b010, 3'b000, 1'b1);
    cycle(3'b000, 3'b000, 1'b0);

    // 21:20 keeps playing, 22:20 wins, then buttons are ignored while blinking.
    cycle(3'b001, 3'b000, 1'b0);
    repeat (20) cycle(3'b011, 3'b000, 1'b0);
    repeat (2) cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b001, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b111, 3'b000, 1'b0);
    cycle(3'b000, 3'b111, 1'b0);
    repeat (12) cycle(3'b000, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 1'b1);

    // Random traffic, biased upward so games are won from time to time.
    repeat (700) begin
      ru = '0;
      rd = '0;
      for (int p = 0; p < N; p++) begin
        ru[p] = ($urandom_range(0, 1) == 0);
        rd[p] = ($urandom_range(0, 7) == 0);
      end
      cycle(ru, rd, ($urandom_range(0, 149) == 0));
    end

    // Asynchronous reset in the middle of a game.
    cycle(3'b000, 3'b000, 1'b1);
    repeat (5) cycle(3'b011, 3'b000, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (2) cycle(3'b000, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
